// File: rtl/modinv_check.sv
// rtl/modinv_check.sv - checks that inv is the modular inverse of a mod m
// Sequential: reduce a mod m by restoring division, then shift-add multiply r*inv mod m.
module modinv_check #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] data_a,
   input  logic [W-1:0] data_b,
   input  logic [W-1:0] inv,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] prod,
   output logic         inv_ok,
   output logic         err
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, REDUCE, MUL, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  a_q, m_q, inv_q;
   logic [W:0]    rem_q, acc_q;
   logic [CW-1:0] cnt_q;

   logic [W:0] m_ext, div_t, div_r, dbl, dbl_r, sum, sum_r, mul_r;
   logic       last;

   // Every operand entering a mod step is < m, so one conditional subtract suffices.
   always_comb begin
      m_ext = {1'b0, m_q};
      div_t = {rem_q[W-1:0], a_q[W-1]};
      div_r = (div_t >= m_ext) ? div_t - m_ext : div_t;
      dbl   = {acc_q[W-1:0], 1'b0};
      dbl_r = (dbl >= m_ext) ? dbl - m_ext : dbl;
      sum   = dbl_r + rem_q;
      sum_r = (sum >= m_ext) ? sum - m_ext : sum;
      mul_r = inv_q[W-1] ? sum_r : dbl_r;
      last  = (cnt_q == LAST);
   end

   // A zero modulus is detected in the first REDUCE cycle, so it reaches DONE one edge after capture.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = REDUCE;
         REDUCE:  if (m_q == '0) state_nx = DONE;
                  else if (last) state_nx = MUL;
         MUL:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         m_q    <= '0;
         inv_q  <= '0;
         rem_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         prod   <= '0;
         inv_ok <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= data_a;
                  m_q   <= data_b;
                  inv_q <= inv;
                  rem_q <= '0;
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            REDUCE: begin
               if (m_q == '0) begin
                  prod   <= '0;
                  inv_ok <= 1'b0;
                  err    <= 1'b1;
               end else begin
                  rem_q <= div_r;
                  a_q   <= {a_q[W-2:0], 1'b0};
                  cnt_q <= last ? '0 : cnt_q + 1'b1;
               end
            end
            MUL: begin
               acc_q <= mul_r;
               inv_q <= {inv_q[W-2:0], 1'b0};
               cnt_q <= last ? '0 : cnt_q + 1'b1;
               if (last) begin
                  prod   <= mul_r[W-1:0];
                  inv_ok <= (mul_r == (W+1)'(m_q != W'(1)));
                  err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_modinv_check.sv
// tb/tb_modinv_check.sv - table-driven bench for modinv_check
// Directed vectors plus hand sequences for ignore-start, back-to-back and mid-job reset.
module tb_modinv_check;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] data_a, data_b, inv;
   logic         busy, done, inv_ok, err;
   logic [W-1:0] prod;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] m;
      logic [W-1:0] iv;
      logic [W-1:0] exp_prod;
      logic         exp_ok;
      logic         exp_err;
   } vec_t;

   vec_t vecs[12];

   modinv_check #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .data_a(data_a), .data_b(data_b), .inv(inv),
      .busy(busy), .done(done), .prod(prod), .inv_ok(inv_ok), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(inout int edges);
      while (!done && edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
      end
   endtask

   task automatic job_check(input string tag, input vec_t v, input int edges);
      chk({tag, " latency"}, edges, (v.m == 0) ? 2 : 2 * W + 1);
      chk({tag, " done"},    int'(done),   1);
      chk({tag, " busy"},    int'(busy),   1);
      chk({tag, " prod"},    int'(prod),   int'(v.exp_prod));
      chk({tag, " inv_ok"},  int'(inv_ok), int'(v.exp_ok));
      chk({tag, " err"},     int'(err),    int'(v.exp_err));
      @(posedge clk);
      #1;
      chk({tag, " done_1cyc"}, int'(done), 0);
      chk({tag, " idle"},      int'(busy), 0);
   endtask

   task automatic run_job(input string tag, input vec_t v);
      int edges;
      @(negedge clk);
      data_a = v.a; data_b = v.m; inv = v.iv; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      start  = 1'b0;
      data_a = W'($urandom);
      data_b = W'($urandom);
      inv    = W'($urandom);
      wait_done(edges);
      job_check(tag, v, edges);
   endtask

   initial begin
      int   edges;
      logic seen;

      vecs[0]  = '{8'd9,   8'd7,   8'd4,   8'd1, 1'b1, 1'b0};
      vecs[1]  = '{8'd15,  8'd24,  8'd5,   8'd3, 1'b0, 1'b0};
      vecs[2]  = '{8'd27,  8'd81,  8'd3,   8'd0, 1'b0, 1'b0};
      vecs[3]  = '{8'd200, 8'd7,   8'd2,   8'd1, 1'b1, 1'b0};
      vecs[4]  = '{8'd5,   8'd0,   8'd3,   8'd0, 1'b0, 1'b1};
      vecs[5]  = '{8'd5,   8'd1,   8'd3,   8'd0, 1'b1, 1'b0};
      vecs[6]  = '{8'd3,   8'd11,  8'd4,   8'd1, 1'b1, 1'b0};
      vecs[7]  = '{8'd255, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0};
      vecs[8]  = '{8'd10,  8'd13,  8'd4,   8'd1, 1'b1, 1'b0};
      vecs[9]  = '{8'd7,   8'd16,  8'd7,   8'd1, 1'b1, 1'b0};
      vecs[10] = '{8'd6,   8'd9,   8'd3,   8'd0, 1'b0, 1'b0};
      vecs[11] = '{8'd255, 8'd254, 8'd255, 8'd1, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; data_a = '0; data_b = '0; inv = '0;
      #12;
      chk("rst busy",   int'(busy),   0);
      chk("rst done",   int'(done),   0);
      chk("rst prod",   int'(prod),   0);
      chk("rst inv_ok", int'(inv_ok), 0);
      chk("rst err",    int'(err),    0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         run_job($sformatf("vec%0d", i), vecs[i]);

      // second start during MUL must be ignored
      @(negedge clk);
      data_a = 8'd9; data_b = 8'd7; inv = 8'd4; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1 start = 1'b0;
      repeat (W + 2) begin
         @(posedge clk);
         edges++;
      end
      #1;
      chk("ign busy", int'(busy), 1);
      data_a = 8'd15; data_b = 8'd24; inv = 8'd5; start = 1'b1;
      @(posedge clk);
      edges++;
      #1 start = 1'b0;
      wait_done(edges);
      job_check("ign", vecs[0], edges);

      // start held high: two jobs with one idle cycle between
      @(negedge clk);
      data_a = 8'd15; data_b = 8'd24; inv = 8'd5; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      wait_done(edges);
      chk("b2b1 latency", edges, 2 * W + 1);
      chk("b2b1 prod", int'(prod), 3);
      @(posedge clk);
      #1;
      chk("b2b gap busy", int'(busy), 0);
      data_a = 8'd3; data_b = 8'd11; inv = 8'd4;
      @(posedge clk);
      #1;
      chk("b2b2 accepted", int'(busy), 1);
      chk("b2b prod held", int'(prod), 3);
      start = 1'b0;
      edges = 1;
      wait_done(edges);
      job_check("b2b2", vecs[6], edges);

      // reset during REDUCE: immediate clear, no done, then a clean job
      @(negedge clk);
      data_a = 8'd27; data_b = 8'd81; inv = 8'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst busy",   int'(busy),   0);
      chk("arst done",   int'(done),   0);
      chk("arst prod",   int'(prod),   0);
      chk("arst inv_ok", int'(inv_ok), 0);
      chk("arst err",    int'(err),    0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1 if (done || busy) seen = 1'b1;
      end
      chk("arst no resume", int'(seen), 0);
      run_job("post_rst", vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
